// File: rtl/riscv_v_logic_wb_stage.sv
// Writeback stage for the vector logic units: byte-merge, write-enable generation, 2-entry skid FIFO.
// Optional RISCV_V_WB_PERF_EN adds a 32-bit retired-writeback counter output.
module riscv_v_logic_wb_stage #(
    parameter int unsigned DATA_WIDTH = 128,
    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8,
    parameter int unsigned VREG_AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [DATA_WIDTH-1:0] in_old_vd,
    input  logic [NUM_BYTES-1:0]  in_byte_en,
    input  logic                  in_is_reduct,
    input  logic [4:0]            in_osize_vector,
    input  logic [VREG_AW-1:0]    in_vd_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_BYTES-1:0]  out_byte_we,
    output logic [VREG_AW-1:0]    out_vd_addr,
    output logic                  busy
`ifdef RISCV_V_WB_PERF_EN
    ,
    output logic [31:0]           perf_retired
`endif
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [NUM_BYTES-1:0]  r_mem_we   [DEPTH];
    logic [VREG_AW-1:0]    r_mem_addr [DEPTH];
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [NUM_BYTES-1:0]  r_out_we;
    logic [VREG_AW-1:0]    r_out_addr;

    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_wr_ptr_nxt;
    logic                  w_rd_ptr_nxt;
    int unsigned           w_red_bytes;
    logic [NUM_BYTES-1:0]  w_red_mask;
    logic [NUM_BYTES-1:0]  w_take;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [NUM_BYTES-1:0]  w_we;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [NUM_BYTES-1:0]  w_head_we;
    logic [VREG_AW-1:0]    w_head_addr;

    assign w_push = in_valid & r_in_ready & ~flush;
    assign w_pop  = r_out_valid & out_ready & ~flush;

    // Reduction writes only element 0; an illegal (non-one-hot) size writes nothing.
    always_comb begin
        w_red_bytes = 0;
        w_red_mask  = '0;
        case (in_osize_vector)
            5'b00001: w_red_bytes = 1;
            5'b00010: w_red_bytes = 2;
            5'b00100: w_red_bytes = 4;
            5'b01000: w_red_bytes = 8;
            5'b10000: w_red_bytes = 16;
            default:  w_red_bytes = 0;
        endcase
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            w_red_mask[i] = in_is_reduct && (i < int'(w_red_bytes));
        end
    end

    always_comb begin
        w_take   = in_byte_en | w_red_mask;
        w_merged = '0;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            w_merged[i*8 +: 8] = w_take[i] ? in_result[i*8 +: 8] : in_old_vd[i*8 +: 8];
        end
        w_we = in_is_reduct ? w_red_mask : '1;
    end

    always_comb begin
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (flush) begin
            w_count_nxt  = '0;
            w_wr_ptr_nxt = 1'b0;
            w_rd_ptr_nxt = 1'b0;
        end else begin
            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push) w_wr_ptr_nxt = ~r_wr_ptr;
            if (w_pop)  w_rd_ptr_nxt = ~r_rd_ptr;
        end
    end

    // Next head entry, forwarding a push that lands in the slot about to become head.
    always_comb begin
        w_head_data = r_mem_data[w_rd_ptr_nxt];
        w_head_we   = r_mem_we[w_rd_ptr_nxt];
        w_head_addr = r_mem_addr[w_rd_ptr_nxt];
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_data = w_merged;
            w_head_we   = w_we;
            w_head_addr = in_vd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_we    <= '0;
            r_out_addr  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_data[i] <= '0;
                r_mem_we[i]   <= '0;
                r_mem_addr[i] <= '0;
            end
        end else begin
            r_count     <= w_count_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_in_ready  <= (w_count_nxt != CNT_W'(DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            r_out_data  <= w_head_data;
            r_out_we    <= w_head_we;
            r_out_addr  <= w_head_addr;
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_merged;
                r_mem_we[r_wr_ptr]   <= w_we;
                r_mem_addr[r_wr_ptr] <= in_vd_addr;
            end
        end
    end

`ifdef RISCV_V_WB_PERF_EN
    logic [31:0] r_perf_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_retired <= '0;
        end else if (w_pop) begin
            r_perf_retired <= r_perf_retired + 32'd1;
        end
    end

    assign perf_retired = r_perf_retired;
`endif

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_byte_we = r_out_we;
    assign out_vd_addr = r_out_addr;
    assign busy        = r_out_valid;

endmodule

// File: tb/tb_riscv_v_logic_wb_stage.sv
// Scoreboard bench for riscv_v_logic_wb_stage: directed vectors in, monitor compares retired writebacks.
module tb_riscv_v_logic_wb_stage;

    localparam int unsigned DW = 128;
    localparam int unsigned NB = DW / 8;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [NB-1:0] we;
        logic [AW-1:0] a;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic [DW-1:0] in_old_vd;
    logic [NB-1:0] in_byte_en;
    logic          in_is_reduct;
    logic [4:0]    in_osize_vector;
    logic [AW-1:0] in_vd_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [NB-1:0] out_byte_we;
    logic [AW-1:0] out_vd_addr;
    logic          busy;
`ifdef RISCV_V_WB_PERF_EN
    logic [31:0]   perf_retired;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    riscv_v_logic_wb_stage #(.DATA_WIDTH(DW), .VREG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_old_vd(in_old_vd), .in_byte_en(in_byte_en),
        .in_is_reduct(in_is_reduct), .in_osize_vector(in_osize_vector), .in_vd_addr(in_vd_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_byte_we(out_byte_we), .out_vd_addr(out_vd_addr),
        .busy(busy)
`ifdef RISCV_V_WB_PERF_EN
        , .perf_retired(perf_retired)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one result and hold it until the handshake completes.
    task automatic send(input logic [DW-1:0] res, input logic [DW-1:0] old, input logic [NB-1:0] be,
                        input logic red, input logic [4:0] os, input logic [AW-1:0] addr,
                        input logic [DW-1:0] ed, input logic [NB-1:0] ew);
        int   cyc = 0;
        logic acc = 1'b0;
        exp_t e;
        in_result = res; in_old_vd = old; in_byte_en = be;
        in_is_reduct = red; in_osize_vector = os; in_vd_addr = addr;
        in_valid = 1'b1;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = in_ready && !flush;
            if (acc) begin
                e.d = ed; e.we = ew; e.a = addr;
                sb.push_back(e);
            end
            @(posedge clk);
            cyc++;
        end
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: whatever is presented while out_ready is high retires at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            n_pops = 0;
        end else if (out_valid && out_ready) begin
            n_pops++;
            if (sb.size() == 0) begin
                chk("unexpected_output", {{(DW-AW){1'b0}}, out_vd_addr}, '1);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_byte_we", DW'(out_byte_we), DW'(e.we));
                chk("out_vd_addr", DW'(out_vd_addr), DW'(e.a));
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_empty", DW'(sb.size()), '0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_result = '0; in_old_vd = '0; in_byte_en = '0;
        in_is_reduct = 1'b0; in_osize_vector = 5'b00001; in_vd_addr = '0;
        #12;
        chk("rst_in_ready", DW'(in_ready), 1);
        chk("rst_out_valid", DW'(out_valid), 0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_byte_we", DW'(out_byte_we), 0);
        chk("rst_out_vd_addr", DW'(out_vd_addr), 0);
        chk("rst_busy", DW'(busy), 0);
`ifdef RISCV_V_WB_PERF_EN
        chk("rst_perf", DW'(perf_retired), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Element-wise merge, then one-cycle latency check.
        send({16{8'hAA}}, {16{8'h55}}, 16'h00FF, 1'b0, 5'b00001, 5'd3,
             128'h5555555555555555AAAAAAAAAAAAAAAA, 16'hFFFF);
        chk("latency_out_valid", DW'(out_valid), 1);

        // Back-to-back vectors at full throughput.
        send(128'hCAFEBABE0BADF00DFEEDFACE12345678, {16{8'h55}}, 16'h0000, 1'b1, 5'b00100, 5'd7,
             128'h55555555555555555555555512345678, 16'h000F);
        send(128'h0123456789ABCDEFFEDCBA9876543210, {16{8'h55}}, 16'h0000, 1'b1, 5'b10000, 5'd8,
             128'h0123456789ABCDEFFEDCBA9876543210, 16'hFFFF);
        send({16{8'hAA}}, {16{8'h55}}, 16'h000F, 1'b1, 5'b00110, 5'd9,
             128'h555555555555555555555555AAAAAAAA, 16'h0000);
        send(128'h00000000000000000000000000000011, {16{8'h55}}, 16'h0000, 1'b1, 5'b00001, 5'd10,
             128'h55555555555555555555555555555511, 16'h0001);
        send({16{8'hFF}}, '0, 16'hA5A5, 1'b0, 5'b00001, 5'd31,
             128'hFF00FF0000FF00FFFF00FF0000FF00FF, 16'hFFFF);
        drain();

        // Backpressure: two accepted, third held until the head drains.
        out_ready = 1'b0;
        send(128'h1, '0, 16'hFFFF, 1'b0, 5'b00001, 5'd1, 128'h1, 16'hFFFF);
        send(128'h2, '0, 16'hFFFF, 1'b0, 5'b00001, 5'd2, 128'h2, 16'hFFFF);
        chk("full_in_ready", DW'(in_ready), 0);
        chk("full_busy", DW'(busy), 1);
        in_result = 128'h3; in_old_vd = '0; in_byte_en = 16'hFFFF;
        in_is_reduct = 1'b0; in_vd_addr = 5'd4; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("held_in_ready", DW'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(128'h3, '0, 16'hFFFF, 1'b0, 5'b00001, 5'd4, 128'h3, 16'hFFFF);
        drain();

        // Flush while full with a push offered the same cycle.
        out_ready = 1'b0;
        send(128'h10, '0, 16'hFFFF, 1'b0, 5'b00001, 5'd11, 128'h10, 16'hFFFF);
        send(128'h20, '0, 16'hFFFF, 1'b0, 5'b00001, 5'd12, 128'h20, 16'hFFFF);
        flush = 1'b1; in_valid = 1'b1; in_result = 128'h30; in_vd_addr = 5'd13;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", DW'(out_valid), 0);
        chk("flush_in_ready", DW'(in_ready), 1);
        chk("flush_busy", DW'(busy), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_flush_idle", DW'(out_valid), 0);
        end
        @(posedge clk); #1;

        // Asynchronous reset mid-stream with one entry buffered.
        out_ready = 1'b0;
        send(128'h40, '0, 16'hFFFF, 1'b0, 5'b00001, 5'd14, 128'h40, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", DW'(out_valid), 0);
        chk("arst_in_ready", DW'(in_ready), 1);
        chk("arst_busy", DW'(busy), 0);
        chk("arst_out_data", out_data, '0);
        chk("arst_out_vd_addr", DW'(out_vd_addr), 0);
        sb.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(128'h50, {16{8'h55}}, 16'h0003, 1'b0, 5'b00001, 5'd15,
             128'h55555555555555555555555555550050, 16'hFFFF);
        send(128'h60, '0, 16'hFFFF, 1'b0, 5'b00001, 5'd16, 128'h60, 16'hFFFF);
        drain();
        @(posedge clk); #1;
`ifdef RISCV_V_WB_PERF_EN
        chk("perf_retired", DW'(perf_retired), DW'(n_pops));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
